// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared stall masks, stage indices and mult/div FSM state type
//                for the 5-stage pipeline stall controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Bit positions inside the stall vector
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // A stage requesting a stall holds itself and everything upstream of it
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_latency_counter
//  Description : Loadable down-counter with hold and zero flag; tracks the
//                remaining EX cycles of a multi-cycle mult/div operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_latency_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             hold_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; otherwise count down towards zero and stick there
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!hold_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Merges ID / EX / MEM stall requests into the 6-bit stall
//                vector, sequences multi-cycle mult/div in EX, enforces the
//                memory-wait timeout and counts stalled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter int DIV_LAT     = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_stall_req,
  input  logic        ex_md_op,
  input  logic        ex_md_is_div,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [5:0]  stall,
  output logic        md_done,
  output logic        md_busy,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  localparam int CNT_W  = $clog2(max_int(MUL_LAT, DIV_LAT));
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // The entry cycle in IDLE already counts as one EX cycle, and the final
  // (done) cycle is the cycle in which the counter reads zero.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  md_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;

  logic             md_load, md_hold, md_zero;
  logic [CNT_W-1:0] md_load_val;
  logic             ex_stall, id_stall, timeout_hit, mem_stall;

  // While reset is asserted every request is masked so outputs stay quiet
  assign id_stall    = reset & id_stall_req;
  assign timeout_hit = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
  // An ack arriving in the timeout cycle wins: the access completes normally
  assign mem_stall   = reset & mem_req & ~mem_ack & ~timeout_hit;
  assign mem_timeout = reset & mem_req & ~mem_ack &  timeout_hit;

  md_latency_counter #(
    .WIDTH (CNT_W)
  ) u_md_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (md_load),
    .load_val_i (md_load_val),
    .hold_i     (md_hold),
    .zero_o     (md_zero)
  );

  // Mult/div sequencer: next state, EX stall request and completion pulse
  always_comb begin
    state_d     = state_q;
    ex_stall    = 1'b0;
    md_done     = 1'b0;
    md_busy     = 1'b0;
    md_load     = 1'b0;
    md_hold     = 1'b1;
    md_load_val = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
    case (state_q)
      IDLE: begin
        if (ex_md_op && reset) begin
          ex_stall = 1'b1;
          md_load  = 1'b1;
          state_d  = MD_RUN;
        end
      end
      MD_RUN: begin
        md_busy = 1'b1;
        if (!md_zero) begin
          md_hold  = 1'b0;
          ex_stall = 1'b1;
        end else if (!mem_stall) begin
          md_done = 1'b1;
          state_d = IDLE;
        end else begin
          // Result is ready but MEM is still frozen; keep EX held
          ex_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Widest active mask wins
  assign stall = (id_stall  ? STALL_ID  : STALL_NONE)
               | (ex_stall  ? STALL_EX  : STALL_NONE)
               | (mem_stall ? STALL_MEM : STALL_NONE);

  // Consecutive memory-wait counter and saturating stall performance counter
  always_comb begin
    wait_cnt_d     = mem_stall ? (wait_cnt_q + WAIT_W'(1)) : '0;
    stall_cycles_d = stall_cycles_q;
    if (stall[STG_PC] && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire
